// File: rtl/core_types_pkg.sv
// core_types_pkg: shared pipeline types, memory-stage FSM states and func3 codes
package core_types_pkg;

    typedef enum logic {IDLE, ACCESS} mem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        Wmem;
        logic        Rmem;
        logic        Wreg;
        logic [2:0]  func3;
    } EXE_out_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        Wreg;
        logic        Rmem;
    } MEM_out_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores and lane select plus sign/zero extension for loads
module load_store_align
    import core_types_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic        misaligned
);
    logic        is_b, is_h, uns;
    logic [1:0]  ln;
    logic [31:0] sh;

    always_comb begin
        is_b        = func3 == F3_B || func3 == F3_BU;
        is_h        = func3 == F3_H || func3 == F3_HU;
        uns         = func3 == F3_BU || func3 == F3_HU;
        // halfword drops lane bit 0, word uses lane 0: misaligned accesses fall back to the aligned unit
        ln          = is_b ? lane : is_h ? {lane[1], 1'b0} : 2'b00;
        misaligned  = is_h ? lane[0] : !is_b && |lane;
        be          = is_b ? 4'b0001 << ln : is_h ? 4'b0011 << ln : 4'b1111;
        wdata       = is_b ? {4{rs2[7:0]}} : is_h ? {2{rs2[15:0]}} : rs2;
        sh          = rdata >> {ln, 3'b000};
        load_result = is_b ? {{24{!uns && sh[7]}}, sh[7:0]} :
                      is_h ? {{16{!uns && sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EXE->WB memory stage with req/ack data memory access; MEM_MISALIGN_TRAP_EN traps misaligned H/W
module mem_stage
    import core_types_pkg::*;
#(
    parameter int MAX_WAIT = 255
)
(
    input  logic        clk,
    input  logic        nRst,
    input  EXE_out_t    exe_in,
    input  logic        exe_valid,
    output logic        stall,
    output MEM_out_t    mem_out,
    output logic        mem_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        bus_err,
    output logic        misalign
);
    mem_state_t  state;
    logic [7:0]  cnt;
    dmem_req_t   rq;
    EXE_out_t    op_q;
    MEM_out_t    pend, imm, done_out;
    logic        pend_v, pend_mis;
    logic        acc, is_mem, trap, launch, imm_v, done, abort;
    logic [3:0]  st_be, unused_be;
    logic [31:0] st_wdata, ld_res, unused_wdata, unused_ld;
    logic        st_mis, unused_mis;

    load_store_align u_st (
        .func3(exe_in.func3), .lane(exe_in.result[1:0]), .rs2(exe_in.rs2), .rdata(dmem_rdata),
        .be(st_be), .wdata(st_wdata), .load_result(unused_ld), .misaligned(st_mis)
    );

    load_store_align u_ld (
        .func3(op_q.func3), .lane(op_q.result[1:0]), .rs2(op_q.rs2), .rdata(dmem_rdata),
        .be(unused_be), .wdata(unused_wdata), .load_result(ld_res), .misaligned(unused_mis)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (exe_in.Wmem || exe_in.Rmem) && st_mis;
`else
    logic unused_st_mis;
    assign unused_st_mis = st_mis;
    assign trap = 1'b0;
`endif

    assign stall      = state == ACCESS && !dmem_ack;
    assign dmem_we    = rq.we;
    assign dmem_addr  = rq.addr;
    assign dmem_wdata = rq.wdata;
    assign dmem_be    = rq.be;

    always_comb begin
        acc      = state == IDLE || dmem_ack;
        is_mem   = exe_in.Wmem || exe_in.Rmem;
        launch   = acc && exe_valid && is_mem && !trap;
        imm_v    = acc && exe_valid && (!is_mem || trap);
        imm      = '{rd: exe_in.rd, result: exe_in.result, Wreg: exe_in.Wreg && !trap, Rmem: 1'b0};
        abort    = state == ACCESS && !dmem_ack && cnt == 8'(MAX_WAIT - 1);
        done     = state == ACCESS && (dmem_ack || abort);
        done_out = '{rd: op_q.rd, result: (abort || op_q.Wmem) ? op_q.result : ld_res,
                     Wreg: op_q.Wreg && !abort && !op_q.Wmem, Rmem: op_q.Rmem && !abort && !op_q.Wmem};
    end

    // an immediate result accepted on a completion edge is parked in pend and emitted next cycle
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            cnt       <= '0;
            dmem_req  <= 1'b0;
            rq        <= '0;
            op_q      <= '0;
            mem_out   <= '0;
            mem_valid <= 1'b0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
            pend      <= '0;
            pend_v    <= 1'b0;
            pend_mis  <= 1'b0;
        end else begin
            state     <= launch ? ACCESS : done ? IDLE : state;
            cnt       <= launch ? 8'd0 : state == ACCESS ? cnt + 8'd1 : cnt;
            dmem_req  <= launch || (dmem_req && !done);
            if (launch) begin
                rq   <= '{we: exe_in.Wmem, addr: {exe_in.result[31:2], 2'b00}, wdata: st_wdata,
                          be: exe_in.Wmem ? st_be : 4'b0000};
                op_q <= exe_in;
            end
            mem_out   <= done ? done_out : pend_v ? pend : imm_v ? imm :
                         '{rd: mem_out.rd, result: mem_out.result, Wreg: 1'b0, Rmem: mem_out.Rmem};
            mem_valid <= done || pend_v || imm_v;
            misalign  <= !done && (pend_v ? pend_mis : imm_v && trap);
            bus_err   <= abort;
            pend_v    <= (done || pend_v) && imm_v;
            pend      <= imm;
            pend_mis  <= trap;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand sequences for mem_stage
module tb_mem_stage;
    import core_types_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    EXE_out_t    exe_in;
    logic        exe_valid;
    logic        stall;
    MEM_out_t    mem_out;
    logic        mem_valid, dmem_req, dmem_we, dmem_ack, bus_err, misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    int          checks = 0;
    int          errors = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .nRst(nRst), .exe_in(exe_in), .exe_valid(exe_valid), .stall(stall),
        .mem_out(mem_out), .mem_valid(mem_valid), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        EXE_out_t    e;
        int          wait_n;
        logic [31:0] rdata;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_res;
        logic        x_wreg;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic EXE_out_t op(input logic [2:0] f3, input logic wm, input logic rm, input logic wr,
                                    input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rs2);
        return '{rs2: rs2, rd: rd, result: res, Wmem: wm, Rmem: rm, Wreg: wr, func3: f3};
    endfunction

    function automatic vec_t mk(input string name, input EXE_out_t e, input int wait_n, input logic [31:0] rdata,
                                input logic [31:0] x_addr, input logic [3:0] x_be, input logic [31:0] x_wdata,
                                input logic [31:0] x_res, input logic x_wreg);
        vec_t v;
        v.name = name; v.e = e; v.wait_n = wait_n; v.rdata = rdata; v.x_addr = x_addr;
        v.x_be = x_be; v.x_wdata = x_wdata; v.x_res = x_res; v.x_wreg = x_wreg;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic is_mem;
        int   st;
        is_mem = v.e.Wmem || v.e.Rmem;
        st = 0;
        @(negedge clk);
        exe_in = v.e; exe_valid = 1'b1; dmem_ack = 1'b0;
        @(posedge clk); #1;
        exe_valid = 1'b0;
        if (is_mem) begin
            chk({v.name, " req"}, dmem_req, 1);
            chk({v.name, " addr"}, dmem_addr, v.x_addr);
            chk({v.name, " be"}, dmem_be, v.x_be);
            chk({v.name, " we"}, dmem_we, v.e.Wmem);
            if (v.e.Wmem) chk({v.name, " wdata"}, dmem_wdata, v.x_wdata);
            for (int i = 0; i < v.wait_n; i++) begin
                st += int'(stall);
                @(posedge clk); #1;
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            #1 chk({v.name, " stall with ack"}, stall, 0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk({v.name, " stall cycles"}, st, v.wait_n);
        end else begin
            chk({v.name, " stall"}, stall, 0);
        end
        chk({v.name, " mem_valid"}, mem_valid, 1);
        chk({v.name, " rd"}, mem_out.rd, v.e.rd);
        chk({v.name, " result"}, mem_out.result, v.x_res);
        chk({v.name, " Wreg"}, mem_out.Wreg, v.x_wreg);
        chk({v.name, " Rmem"}, mem_out.Rmem, v.e.Rmem && !v.e.Wmem);
        chk({v.name, " req after"}, dmem_req, 0);
    endtask

    initial begin
        int n;
        exe_in = '0; exe_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        vq.push_back(mk("ADD", op(3'b000, 0, 0, 1, 5, 32'h1234, 0), 0, 0, 0, 0, 0, 32'h1234, 1));
        vq.push_back(mk("LB 103", op(F3_B, 0, 1, 1, 7, 32'h103, 0), 2, 32'h80FF_0000, 32'h100, 4'h0, 0, 32'hFFFF_FF80, 1));
        vq.push_back(mk("LBU 103", op(F3_BU, 0, 1, 1, 7, 32'h103, 0), 2, 32'h80FF_0000, 32'h100, 4'h0, 0, 32'h0000_0080, 1));
        vq.push_back(mk("SH 202", op(F3_H, 1, 0, 1, 3, 32'h202, 32'hAAAA_BEEF), 0, 0, 32'h200, 4'hC, 32'hBEEF_BEEF, 32'h202, 0));
        vq.push_back(mk("LH 102", op(F3_H, 0, 1, 1, 9, 32'h102, 0), 1, 32'h8001_1234, 32'h100, 4'h0, 0, 32'hFFFF_8001, 1));
        vq.push_back(mk("LHU 100", op(F3_HU, 0, 1, 1, 10, 32'h100, 0), 1, 32'h8001_F234, 32'h100, 4'h0, 0, 32'h0000_F234, 1));
        vq.push_back(mk("SB 301", op(F3_B, 1, 0, 0, 11, 32'h301, 32'h1234_5678), 0, 0, 32'h300, 4'h2, 32'h7878_7878, 32'h301, 0));
        vq.push_back(mk("LW ack at limit", op(F3_W, 0, 1, 1, 12, 32'h104, 0), 3, 32'hDEAD_BEEF, 32'h104, 4'h0, 0, 32'hDEAD_BEEF, 1));
        vq.push_back(mk("SW 108", op(F3_W, 1, 0, 0, 13, 32'h108, 32'hCAFE_F00D), 0, 0, 32'h108, 4'hF, 32'hCAFE_F00D, 32'h108, 0));
        vq.push_back(mk("L f3=011", op(3'b011, 0, 1, 1, 14, 32'h10C, 0), 0, 32'h8765_4321, 32'h10C, 4'h0, 0, 32'h8765_4321, 1));
        vq.push_back(mk("LB pos", op(F3_B, 0, 1, 1, 15, 32'h100, 0), 0, 32'h0000_007F, 32'h100, 4'h0, 0, 32'h0000_007F, 1));

        #12;
        chk("rst mem_valid", mem_valid, 0);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst mem_out", mem_out, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst misalign", misalign, 0);
        chk("rst dmem_we", dmem_we, 0);
        chk("rst stall", stall, 0);
        @(negedge clk) nRst = 1'b1;

        foreach (vq[i]) run_vec(vq[i]);

        // invalid slot
        @(negedge clk);
        exe_in = op(3'b000, 0, 0, 1, 9, 32'h99, 0); exe_valid = 1'b0;
        @(posedge clk); #1;
        chk("invalid mem_valid", mem_valid, 0);
        chk("invalid Wreg", mem_out.Wreg, 0);

        // back-to-back loads keep dmem_req high
        @(negedge clk);
        exe_in = op(F3_W, 0, 1, 1, 1, 32'h10, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_in = op(F3_W, 0, 1, 1, 2, 32'h14, 0);
        chk("b2b addr0", dmem_addr, 32'h10);
        chk("b2b stall", stall, 1);
        @(posedge clk); #1;
        chk("b2b req hold", dmem_req, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dmem_ack = 1'b0; exe_valid = 1'b0;
        chk("b2b req ack edge", dmem_req, 1);
        chk("b2b addr1", dmem_addr, 32'h14);
        chk("b2b valid0", mem_valid, 1);
        chk("b2b res0", mem_out.result, 32'h1111_1111);
        chk("b2b rd0", mem_out.rd, 1);
        @(posedge clk); #1;
        chk("b2b req 2nd", dmem_req, 1);
        chk("b2b gap valid", mem_valid, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("b2b res1", mem_out.result, 32'h2222_2222);
        chk("b2b rd1", mem_out.rd, 2);
        chk("b2b req end", dmem_req, 0);

        // abort after MAX_WAIT cycles without ack
        @(negedge clk);
        exe_in = op(F3_W, 0, 1, 1, 3, 32'h20, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_valid = 1'b0;
        n = 0;
        while (dmem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort cycles", n, 4);
        chk("abort bus_err", bus_err, 1);
        chk("abort mem_valid", mem_valid, 1);
        chk("abort Wreg", mem_out.Wreg, 0);
        chk("abort stall", stall, 0);
        @(posedge clk); #1;
        chk("abort pulse end", bus_err, 0);
        run_vec(vq[0]);

        // non-memory op accepted on the ack edge is not lost
        @(negedge clk);
        exe_in = op(F3_W, 0, 1, 1, 4, 32'h30, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_in = op(3'b000, 0, 0, 1, 6, 32'h66, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h33;
        @(posedge clk); #1;
        exe_valid = 1'b0; dmem_ack = 1'b0;
        chk("follow load rd", mem_out.rd, 4);
        chk("follow load res", mem_out.result, 32'h33);
        @(posedge clk); #1;
        chk("follow alu valid", mem_valid, 1);
        chk("follow alu rd", mem_out.rd, 6);
        chk("follow alu res", mem_out.result, 32'h66);
        @(posedge clk); #1;
        chk("follow idle", mem_valid, 0);

        // misaligned word and halfword loads
        @(negedge clk);
        exe_in = op(F3_W, 0, 1, 1, 8, 32'h102, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misW req", dmem_req, 0);
        chk("misW pulse", misalign, 1);
        chk("misW valid", mem_valid, 1);
        chk("misW Wreg", mem_out.Wreg, 0);
        @(posedge clk); #1;
        chk("misW pulse end", misalign, 0);
`else
        chk("misW req", dmem_req, 1);
        chk("misW addr", dmem_addr, 32'h100);
        chk("misW misalign", misalign, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h4444_4444;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("misW res", mem_out.result, 32'h4444_4444);
        @(negedge clk);
        exe_in = op(F3_H, 0, 1, 1, 8, 32'h103, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_valid = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hABCD_0012;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("misH res", mem_out.result, 32'hFFFF_ABCD);
        chk("misH misalign", misalign, 0);
`endif

        // asynchronous reset mid-access
        @(negedge clk);
        exe_in = op(F3_W, 0, 1, 1, 2, 32'h40, 0); exe_valid = 1'b1;
        @(posedge clk); #1;
        exe_valid = 1'b0;
        chk("rst mid req", dmem_req, 1);
        #2 nRst = 1'b0;
        #1;
        chk("rst mid req clr", dmem_req, 0);
        chk("rst mid stall", stall, 0);
        chk("rst mid valid", mem_valid, 0);
        @(negedge clk) nRst = 1'b1;
        run_vec(vq[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
